// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer for the RV32 core
// Optional perf counters (cycle_cnt, instret_cnt) are built when INSTR_SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_wen,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       state,
  output logic             fault
`ifdef INSTR_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Out-of-range parameters park the sequencer in FAULT instead of misbehaving silently.
  localparam logic       CFG_OK   = (MEM_TIMEOUT >= 1) && (MEM_TIMEOUT <= 255) && (CNT_W >= 1);
  localparam logic [7:0] TMO_LAST = 8'((MEM_TIMEOUT >= 1) ? (MEM_TIMEOUT - 1) : 0);

  logic [2:0] state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [7:0] tmo_q, tmo_d;

  logic op_legal;
  logic op_is_mem;
  logic tmo_expired;
  logic [2:0] boundary_state;

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  end

  assign op_is_mem      = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign tmo_expired    = (tmo_q == TMO_LAST);
  // run is only consulted where an instruction retires, so a stop never cuts one short.
  assign boundary_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tmo_d    = tmo_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    rf_wen   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    fault    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          op_d    = instr[6:0];
          tmo_d   = 8'd0;
          state_d = S_DECODE;
        end else if (tmo_expired) begin
          tmo_d   = 8'd0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_DECODE: begin
        state_d = op_legal ? S_EXEC : S_FAULT;
      end

      S_EXEC: begin
        if (op_is_mem) begin
          state_d = S_MEM;
        end else if (op_q == OP_BRANCH) begin
          pc_en   = 1'b1;
          state_d = boundary_state;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          tmo_d = 8'd0;
          if (op_q == OP_STORE) begin
            pc_en   = 1'b1;
            state_d = boundary_state;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_expired) begin
          tmo_d   = 8'd0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_WB: begin
        rf_wen  = 1'b1;
        pc_en   = 1'b1;
        state_d = boundary_state;
      end

      // S_FAULT and the unused code 7 both behave as FAULT.
      default: begin
        fault   = 1'b1;
        state_d = S_FAULT;
      end
    endcase

    if (!CFG_OK) state_d = S_FAULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 7'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
    end
  end

  assign state = state_q;

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
  logic             seq_active;

  assign seq_active = (state_q >= S_FETCH) && (state_q <= S_WB);

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (seq_active) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pc_en)      instret_cnt_d = instret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
// Table vectors, hand-written corner sequences and a randomized run against a latency-level model.
module tb_instr_sequencer;

  localparam int MT = 15;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_ADDI = 32'h00108093;
  localparam logic [31:0] W_LW   = 32'h0000A183;
  localparam logic [31:0] W_SW   = 32'h00112023;
  localparam logic [31:0] W_BEQ  = 32'h00208463;
  localparam logic [31:0] W_JAL  = 32'h008000EF;
  localparam logic [31:0] W_ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_load;
  logic        pc_en;
  logic        rf_wen;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  state;
  logic        fault;
`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  instr_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .instr    (instr),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .imem_req (imem_req),
    .ir_load  (ir_load),
    .pc_en    (pc_en),
    .rf_wen   (rf_wen),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .state    (state),
    .fault    (fault)
`ifdef INSTR_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return 32'({imem_req, ir_load, pc_en, rf_wen, dmem_req, dmem_we, fault});
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    instr    = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
  endtask

  // Memory responders ack after fd / md un-acked request cycles; an instruction ends on pc_en or IDLE/FAULT.
  task automatic run_instr(input logic [31:0] word, input int fd, input int md, input logic run_after,
                           output int cycles, output int pcs, output int rfs,
                           output int mem_cyc, output int we_cyc);
    int fcnt;
    int mcnt;
    bit done;
    cycles = 0; pcs = 0; rfs = 0; mem_cyc = 0; we_cyc = 0;
    fcnt = 0; mcnt = 0; done = 0;
    @(posedge clk);
    #1;
    run = run_after;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      instr    = word;
      imem_ack = imem_req && (fcnt == fd);
      dmem_ack = dmem_req && (mcnt == md);
      @(negedge clk);
      if (state == 3'd0 || state == 3'd6) begin
        done = 1;
      end else begin
        cycles++;
        if (imem_req) fcnt++;
        if (dmem_req) begin
          mcnt++;
          mem_cyc++;
          if (dmem_we) we_cyc++;
        end
        if (rf_wen) rfs++;
        if (pc_en) begin
          pcs++;
          done = 1;
        end
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] word;
    int          fd;
    int          md;
    int          cyc;
    int          pcs;
    int          rfs;
    int          we;
    int          fin;
  } vec_t;

  // Class ids for the random model: 0=R 1=I 2=LOAD 3=STORE 4=BRANCH 5=JAL
  function automatic int model_cycles(input int cls, input int fd, input int md);
    int fetch_part;
    int mem_part;
    fetch_part = fd + 1;
    mem_part   = md + 1;
    case (cls)
      4:       return fetch_part + 2;
      2:       return fetch_part + 2 + mem_part + 1;
      3:       return fetch_part + 2 + mem_part;
      default: return fetch_part + 3;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit, got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[13];
    logic [31:0] words[6];
    int          seq[4];
    int          cyc, pcs, rfs, memc, wec;
    int          found;

    tbl[0]  = '{"add",        W_ADD,  0,  0,  4, 1, 1, 0,  0};
    tbl[1]  = '{"addi",       W_ADDI, 0,  0,  4, 1, 1, 0,  0};
    tbl[2]  = '{"jal",        W_JAL,  0,  0,  4, 1, 1, 0,  0};
    tbl[3]  = '{"beq",        W_BEQ,  0,  0,  3, 1, 0, 0,  0};
    tbl[4]  = '{"sw",         W_SW,   0,  0,  4, 1, 0, 1,  0};
    tbl[5]  = '{"lw",         W_LW,   0,  0,  5, 1, 1, 0,  0};
    tbl[6]  = '{"lw_wait3",   W_LW,   0,  3,  8, 1, 1, 0,  0};
    tbl[7]  = '{"sw_wait3",   W_SW,   0,  3,  7, 1, 0, 4,  0};
    tbl[8]  = '{"fetch_exp",  W_ADD,  14, 0, 18, 1, 1, 0,  0};
    tbl[9]  = '{"fetch_tmo",  W_ADD,  15, 0, 15, 0, 0, 0,  6};
    tbl[10] = '{"illegal",    W_ILL,  0,  0,  2, 0, 0, 0,  6};
    tbl[11] = '{"dmem_tmo",   W_LW,   0,  15, 18, 0, 0, 0, 6};
    tbl[12] = '{"dmem_exp",   W_SW,   0,  14, 18, 1, 0, 15, 0};

    words[0] = W_ADD; words[1] = W_ADDI; words[2] = W_LW;
    words[3] = W_SW;  words[4] = W_BEQ;  words[5] = W_JAL;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 5;

    // Reset state
    rst = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; instr = W_ADD;
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", outs(), 32'd0);

    // Single instructions with run dropped after fetch starts
    foreach (tbl[i]) begin
      do_reset();
      run_instr(tbl[i].word, tbl[i].fd, tbl[i].md, 1'b0, cyc, pcs, rfs, memc, wec);
      check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
      check({tbl[i].name, "_pc_en"},  32'(pcs), 32'(tbl[i].pcs));
      check({tbl[i].name, "_rf_wen"}, 32'(rfs), 32'(tbl[i].rfs));
      check({tbl[i].name, "_we"},     32'(wec), 32'(tbl[i].we));
      @(posedge clk);
      @(negedge clk);
      check({tbl[i].name, "_final"},  32'(state), 32'(tbl[i].fin));
    end

    // Fault is sticky and ignores run and acks
    do_reset();
    run_instr(W_ADD, 15, 0, 1'b1, cyc, pcs, rfs, memc, wec);
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("fault_sticky_state", 32'(state), 32'd6);
      check("fault_sticky_outs", outs(), 32'd1);
    end

    // Back-to-back add stream
    do_reset();
    instr = W_ADD; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("add_stream_state", 32'(state), 32'(seq[k % 4]));
      check("add_stream_wb", 32'({rf_wen, pc_en}), (k % 4 == 3) ? 32'd3 : 32'd0);
    end

    // Async reset in the middle of a data access
    do_reset();
    instr = W_LW; imem_ack = 1'b1; dmem_ack = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (state == 3'd4) found = 1;
    end
    check("rst_mid_mem_reached", 32'(found), 32'd1);
    check("rst_mid_mem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_outs", outs(), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_outs", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Branch with run dropped during EXEC
    do_reset();
    instr = W_BEQ; imem_ack = 1'b1; dmem_ack = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (state == 3'd3) begin
        run = 1'b0;
        found = 1;
      end
    end
    @(negedge clk);
    check("beq_drop_exec", 32'(state), 32'd3);
    check("beq_drop_pc_en", 32'(pc_en), 32'd1);
    pcs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (pc_en) pcs++;
      check("beq_drop_idle", 32'(state), 32'd0);
    end
    check("beq_drop_no_more_pc", 32'(pcs), 32'd0);

    // Randomized instruction stream against the latency model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int cls, fd, md, exp_mem;
      cls = int'($urandom_range(0, 5));
      fd  = ($urandom_range(0, 3) == 0) ? MT - 1 : int'($urandom_range(0, 4));
      md  = ($urandom_range(0, 3) == 0) ? MT - 1 : int'($urandom_range(0, 4));
      exp_mem = (cls == 2 || cls == 3) ? md + 1 : 0;
      run_instr(words[cls], fd, md, 1'b1, cyc, pcs, rfs, memc, wec);
      check("rand_cycles", 32'(cyc), 32'(model_cycles(cls, fd, md)));
      check("rand_pc_en", 32'(pcs), 32'd1);
      check("rand_rf_wen", 32'(rfs), (cls == 3 || cls == 4) ? 32'd0 : 32'd1);
      check("rand_mem_cycles", 32'(memc), 32'(exp_mem));
      check("rand_we_cycles", 32'(wec), (cls == 3) ? 32'(exp_mem) : 32'd0);
    end
    check("rand_no_fault", 32'(fault), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
